data_router: RTL
================

// Module: data_router
// PURPOSE
//  1-to-2 steering stage: the opposite direction of the datapath 2:1 selector.
//  Takes one WIDTH-bit result stream with a select bit and delivers each word to
//  destination S (sel=1) or T (sel=0) through a registered 1-entry output slot
//  per port, with valid/ready handshakes on all three sides. Sits between the
//  ALU/result bus and two downstream consumers (e.g. reg-file write port, store path).
// PARAMETERS
//  WIDTH   32  data width of input and both outputs
//  CNT_W   16  width of per-port transfer counters (only with DATA_ROUTER_STATS_EN)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous assert, active-low reset
//  in_valid     in   1      input word valid
//  in_ready     out  1      router accepts input this cycle
//  in_sel       in   1      1 -> port S, 0 -> port T; sampled with in_data
//  in_data      in   WIDTH  input word
//  s_valid      out  1      port S slot holds a word
//  s_ready      in   1      port S consumer accepts
//  s_data       out  WIDTH  port S word
//  t_valid      out  1      port T slot holds a word
//  t_ready      in   1      port T consumer accepts
//  t_data       out  WIDTH  port T word
//  s_count      out  CNT_W  S transfers completed (DATA_ROUTER_STATS_EN only)
//  t_count      out  CNT_W  T transfers completed (DATA_ROUTER_STATS_EN only)
//  stats_clr    in   1      sync clear of both counters (DATA_ROUTER_STATS_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): s_valid=t_valid=0, s_data=t_data=0, counters=0.
//    Reset mid-transfer drops any held word; no partial outputs after release.
//  - Slot state per port: EMPTY / FULL. free_x = !x_valid | x_ready.
//  - in_ready = in_sel ? free_s : free_t (combinational from in_sel, x_valid,
//    x_ready; no combinational path from in_data).
//  - Input transfer = in_valid & in_ready; target slot loads in_data, goes FULL
//    next cycle. Latency input->output valid: exactly 1 cycle.
//  - Output transfer = x_valid & x_ready; slot goes EMPTY unless reloaded the
//    same cycle (simultaneous drain+load -> stays FULL with new data, full
//    throughput 1 word/cycle per port).
//  - Non-target slot is unaffected by an input transfer. Head-of-line blocking
//    allowed: word for a FULL, stalled port stalls input even if other port free.
//  - Held x_data stable while x_valid & !x_ready. x_valid never drops without x_ready.
//  - Order preserved per port; no ordering guarantee between S and T.
//  - in_valid=0: in_ready still reflects in_sel (don't-care to upstream).
// CONFIGURATION
//  - DATA_ROUTER_STATS_EN defined: s_count/t_count increment by 1 on each output
//    transfer of that port, wrap modulo 2^CNT_W; stats_clr=1 forces 0 next edge,
//    clear has priority over same-cycle increment.
//  - Not defined: s_count, t_count, stats_clr ports absent; no counter logic.
// STRUCTURE
//  - Package data_router_pkg: localparams SEL_S=1'b1, SEL_T=1'b0; typedef enum
//    logic {SLOT_EMPTY, SLOT_FULL} slot_state_t.
//  - Sub-module router_slot (WIDTH param): one-entry registered valid/ready
//    buffer with load/drain; instantiated twice (S, T). Top holds steering,
//    in_ready mux and optional counters.
// TESTING
//  1 Reset: rst_n=0 with slots FULL -> s_valid=t_valid=0, data=0 immediately
//    (async), counts=0.
//  2 Steering: send 0xAAAA0001 sel=1, 0x5555_0002 sel=0, both readies=1 ->
//    s_data=0xAAAA0001 at cycle+1, t_data=0x55550002 at cycle+2, other valid low.
//  3 Back-pressure: s_ready=0, send 2 words sel=1 -> first held stable in slot,
//    in_ready=0 for second; raise s_ready -> second appears next cycle, none lost.
//  4 Throughput: s_ready=1, 8 back-to-back sel=1 words -> s_valid high 8
//    consecutive cycles, in order, in_ready constantly 1.
//  5 HOL block: S FULL stalled, present sel=0 then sel=1 -> sel=0 accepted
//    into T; sel=1 word stalls; T still drains independently.
//  6 Stats (DATA_ROUTER_STATS_EN, CNT_W=4): 17 S transfers -> s_count=1 (wrap);
//    stats_clr with concurrent transfer -> 0.

Source files
------------

// File: rtl/data_router_pkg.sv
// Shared select encodings and slot state type for the 1-to-2 data router.
package data_router_pkg;

  localparam logic SEL_S = 1'b1;
  localparam logic SEL_T = 1'b0;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

endpackage

// File: rtl/data_router_slot.sv
// One-entry registered valid/ready output buffer; load and drain may coincide.
module router_slot
  import data_router_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             free_o
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A slot can accept a word when empty or when its current word leaves this cycle.
  assign free_o  = (state_q == SLOT_EMPTY) | ready_i;
  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = SLOT_FULL;
      data_d  = data_i;
    end else if (ready_i) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/data_router.sv
// 1-to-2 steering stage: routes each input word to port S (sel=1) or T (sel=0).
// Optional per-port transfer counters are built when DATA_ROUTER_STATS_EN is defined.
module data_router
  import data_router_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef DATA_ROUTER_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DATA_ROUTER_STATS_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] s_count,
  output logic [CNT_W-1:0] t_count,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [WIDTH-1:0] s_data,
  output logic             t_valid,
  input  logic             t_ready,
  output logic [WIDTH-1:0] t_data
);

  logic free_s, free_t;
  logic load_s, load_t;

  // Readiness depends only on the selected slot, so a stalled target blocks the input.
  assign in_ready = (in_sel == SEL_S) ? free_s : free_t;
  assign load_s   = in_valid & in_ready & (in_sel == SEL_S);
  assign load_t   = in_valid & in_ready & (in_sel == SEL_T);

  router_slot #(.WIDTH(WIDTH)) u_slot_s (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_s),
    .data_i  (in_data),
    .ready_i (s_ready),
    .valid_o (s_valid),
    .data_o  (s_data),
    .free_o  (free_s)
  );

  router_slot #(.WIDTH(WIDTH)) u_slot_t (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_t),
    .data_i  (in_data),
    .ready_i (t_ready),
    .valid_o (t_valid),
    .data_o  (t_data),
    .free_o  (free_t)
  );

`ifdef DATA_ROUTER_STATS_EN
  logic [CNT_W-1:0] s_cnt_q, s_cnt_d;
  logic [CNT_W-1:0] t_cnt_q, t_cnt_d;

  // Clear wins over a same-cycle increment; counters wrap naturally.
  always_comb begin
    s_cnt_d = s_cnt_q;
    t_cnt_d = t_cnt_q;
    if (stats_clr) begin
      s_cnt_d = '0;
      t_cnt_d = '0;
    end else begin
      if (s_valid & s_ready) s_cnt_d = s_cnt_q + CNT_W'(1);
      if (t_valid & t_ready) t_cnt_d = t_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt_q <= '0;
      t_cnt_q <= '0;
    end else begin
      s_cnt_q <= s_cnt_d;
      t_cnt_q <= t_cnt_d;
    end
  end

  assign s_count = s_cnt_q;
  assign t_count = t_cnt_q;
`endif

endmodule
